sdram_host_if: RTL and testbench

Host-side front end for the SDRAM command FSM. Accepts single-word read/write requests from the host, holds them until the FSM picks them up, and maintains the refresh-interval counter the FSM uses to decide when to refresh. Decodes the FSM's state to drive SDRAM address, bank and DQ lines aligned with the command bus, and returns read data. Sits directly upstream of the command FSM and alongside it on the SDRAM pins.

---
 rtl/sdram_host_if.sv | 169 ++++++++++++++++
 tb/tb_sdram_host_if.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_if.sv
// Host-side front end for the SDRAM command FSM.
// Holds one host request until the FSM completes it, keeps the refresh-interval
// counter, decodes the FSM state into A/BA/DQ pin values, and returns read data.
module sdram_host_if #(
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16,
    parameter logic [ROW_W-1:0] MODE_REG = 'h020
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          rd_req,
    input  logic                          wr_req,
    input  logic [BANK_W+ROW_W+COL_W-1:0] addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          busy,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic [4:0]                    fsm_state,
    output logic                          rd_enable,
    output logic                          wr_enable,
    output logic [9:0]                    refresh_cnt,
    output logic [ROW_W-1:0]              sdram_addr,
    output logic [BANK_W-1:0]             sdram_ba,
    output logic [DATA_W-1:0]             sdram_dq_out,
    output logic                          sdram_dq_oe,
    input  logic [DATA_W-1:0]             sdram_dq_in
);

    // Command FSM state codes this block reacts to; all other codes decode to idle pins.
    typedef enum logic [4:0] {
        ST_IDLE     = 5'd0,
        ST_REF_PRE  = 5'd1,
        ST_REF_AR   = 5'd3,
        ST_INIT_PRE = 5'd9,
        ST_LMR      = 5'd14,
        ST_RD_ACT   = 5'd16,
        ST_RD_CMD   = 5'd18,
        ST_RD_DATA  = 5'd20,
        ST_WR_ACT   = 5'd24,
        ST_WR_CMD   = 5'd26
    } fsm_code_e;

    // A10 high selects auto-precharge on READ/WRITE and all-banks on PRECHARGE.
    localparam logic [ROW_W-1:0] A10_MASK = ROW_W'(1) << 10;
    localparam logic [9:0]       CNT_MAX  = 10'd1023;

    logic                init_done_q, init_done_d;
    logic                pending_q,   pending_d;
    logic                op_read_q,   op_read_d;
    logic [BANK_W-1:0]   bank_q,      bank_d;
    logic [ROW_W-1:0]    row_q,       row_d;
    logic [COL_W-1:0]    col_q,       col_d;
    logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
    logic [DATA_W-1:0]   rd_data_q,   rd_data_d;
    logic                rd_valid_q,  rd_valid_d;
    logic [9:0]          refresh_q,   refresh_d;

    logic init_done;
    logic accept;
    logic rd_done;
    logic wr_done;

    // Init counts as done from the first IDLE cycle so busy drops in that same cycle.
    assign init_done = init_done_q | (fsm_state == ST_IDLE);
    assign busy      = ~init_done | pending_q;
    assign accept    = (rd_req | wr_req) & ~busy;
    assign rd_done   = pending_q & op_read_q  & (fsm_state == ST_RD_DATA);
    assign wr_done   = pending_q & ~op_read_q & (fsm_state == ST_WR_CMD);

    assign rd_enable   = pending_q & op_read_q;
    assign wr_enable   = pending_q & ~op_read_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign refresh_cnt = refresh_q;

    // Next-state logic for the request latch, read return and refresh counter.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        init_done_d = init_done;
        pending_d   = pending_q;
        op_read_d   = op_read_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        wr_data_d   = wr_data_q;
        rd_valid_d  = rd_done;
        rd_data_d   = rd_done ? sdram_dq_in : rd_data_q;
        refresh_d   = refresh_q;

        if (rd_done || wr_done) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
            op_read_d = rd_req;           // read wins when both are requested
            {bank_d, row_d, col_d} = addr;
            wr_data_d = wr_data;
        end

        if (!init_done || fsm_state == ST_REF_AR) begin
            refresh_d = '0;
        end else if (refresh_q != CNT_MAX) begin
            refresh_d = refresh_q + 10'd1;
        end
    end

    // State registers; a reset drops any pending request and restarts the init wait.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            init_done_q <= 1'b0;
            pending_q   <= 1'b0;
            op_read_q   <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            refresh_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            init_done_q <= init_done_d;
            pending_q   <= pending_d;
            op_read_q   <= op_read_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            refresh_q   <= refresh_d;
        end
    end

    // Pin decode: address, bank and DQ drive aligned with the command on the bus.
    always_comb begin
        sdram_addr   = '0;
        sdram_ba     = '0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        case (fsm_state)
            ST_RD_ACT, ST_WR_ACT: begin
                sdram_ba   = bank_q;
                sdram_addr = row_q;
            end
            ST_RD_CMD: begin
                sdram_ba   = bank_q;
                sdram_addr = A10_MASK | ROW_W'(col_q);
            end
            ST_WR_CMD: begin
                sdram_ba     = bank_q;
                sdram_addr   = A10_MASK | ROW_W'(col_q);
                sdram_dq_oe  = 1'b1;
                sdram_dq_out = wr_data_q;
            end
            ST_REF_PRE, ST_INIT_PRE: begin
                sdram_addr = A10_MASK;
            end
            ST_LMR: begin
                sdram_addr = MODE_REG;
            end
            default: begin
                sdram_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_host_if.sv
// Directed bench for sdram_host_if: the bench plays the command FSM by driving
// fsm_state cycle by cycle and checks pins, handshakes and the refresh counter.
module tb_sdram_host_if;

    logic        CLK;
    logic        RESET;
    logic        rd_req;
    logic        wr_req;
    logic [23:0] addr;
    logic [15:0] wr_data;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [4:0]  fsm_state;
    logic        rd_enable;
    logic        wr_enable;
    logic [9:0]  refresh_cnt;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_in;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_host_if dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .addr         (addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fsm_state    (fsm_state),
        .rd_enable    (rd_enable),
        .wr_enable    (wr_enable),
        .refresh_cnt  (refresh_cnt),
        .sdram_addr   (sdram_addr),
        .sdram_ba     (sdram_ba),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe),
        .sdram_dq_in  (sdram_dq_in)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  st;
        logic [12:0] exp_addr;
        logic [1:0]  exp_ba;
        logic        exp_oe;
        logic [15:0] exp_dq;
    } dec_vec_t;

    dec_vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: through the rising edge, back to the falling edge for drive/sample.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [4:0] st);
        fsm_state = st;
        #1;
    endtask

    initial begin
        // write request {bank 1, row 0x0F0, col 0x1FF}, data 0x1234
        vecs[0]  = '{5'd0,  13'h000, 2'd0, 1'b0, 16'h0000};
        vecs[1]  = '{5'd1,  13'h400, 2'd0, 1'b0, 16'h0000};
        vecs[2]  = '{5'd3,  13'h000, 2'd0, 1'b0, 16'h0000};
        vecs[3]  = '{5'd9,  13'h400, 2'd0, 1'b0, 16'h0000};
        vecs[4]  = '{5'd14, 13'h020, 2'd0, 1'b0, 16'h0000};
        vecs[5]  = '{5'd5,  13'h000, 2'd0, 1'b0, 16'h0000};
        vecs[6]  = '{5'd16, 13'h0F0, 2'd1, 1'b0, 16'h0000};
        vecs[7]  = '{5'd24, 13'h0F0, 2'd1, 1'b0, 16'h0000};
        vecs[8]  = '{5'd18, 13'h5FF, 2'd1, 1'b0, 16'h0000};
        vecs[9]  = '{5'd20, 13'h000, 2'd0, 1'b0, 16'h0000};
        vecs[10] = '{5'd26, 13'h5FF, 2'd1, 1'b1, 16'h1234};

        RESET = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        addr = '0;
        wr_data = '0;
        fsm_state = 5'd8;
        sdram_dq_in = '0;

        // ---- reset values
        @(negedge CLK);
        #1;
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_en", rd_enable, 0);
        check("rst_wr_en", wr_enable, 0);
        check("rst_refresh", refresh_cnt, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_oe", sdram_dq_oe, 0);
        tick();
        RESET = 1'b0;

        // ---- init sequence; a read request during init must be ignored
        drive(5'd8); tick();
        drive(5'd9);
        check("init_pre_addr", sdram_addr, 13'h400);
        check("init_pre_ba", sdram_ba, 0);
        tick();
        rd_req = 1'b1;
        addr = {2'd3, 13'h0777, 9'h011};
        drive(5'd11);
        check("init_busy", busy, 1);
        tick();
        drive(5'd3);
        check("init_refresh_zero", refresh_cnt, 0);
        tick();
        drive(5'd14);
        check("init_lmr_addr", sdram_addr, 13'h020);
        tick();
        rd_req = 1'b0;
        drive(5'd15);
        check("init_req_ignored", rd_enable, 0);
        tick();
        drive(5'd0);
        check("idle_busy_low", busy, 0);
        check("idle_refresh_start", refresh_cnt, 0);
        tick();
        check("idle_refresh_count", refresh_cnt, 1);

        // ---- simultaneous read+write: read wins; a second request while busy is dropped
        addr = {2'd2, 13'h1A5, 9'h033};
        wr_data = 16'h5555;
        rd_req = 1'b1;
        wr_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
        #1;
        check("rd_acc_busy", busy, 1);
        check("rd_acc_rd_en", rd_enable, 1);
        check("rd_acc_wr_en", wr_enable, 0);
        tick();
        wr_req = 1'b1;
        addr = 24'hFFFFFF;
        wr_data = 16'hAAAA;
        drive(5'd16);
        check("rd_act_ba", sdram_ba, 2);
        check("rd_act_addr", sdram_addr, 13'h1A5);
        tick();
        drive(5'd18);
        check("rd_cmd_ba", sdram_ba, 2);
        check("rd_cmd_addr", sdram_addr, 13'h433);
        check("rd_cmd_oe", sdram_dq_oe, 0);
        tick();
        wr_req = 1'b0;
        sdram_dq_in = 16'hBEEF;
        drive(5'd20);
        check("rd_slot_valid", rd_valid, 0);
        tick();
        sdram_dq_in = 16'h0000;
        drive(5'd0);
        check("rd_valid_pulse", rd_valid, 1);
        check("rd_data", rd_data, 16'hBEEF);
        check("rd_done_busy", busy, 0);
        check("rd_done_rd_en", rd_enable, 0);
        check("rd_done_wr_en", wr_enable, 0);
        tick();
        check("rd_valid_drop", rd_valid, 0);
        check("rd_data_hold", rd_data, 16'hBEEF);
        check("second_req_dropped", wr_enable, 0);

        // ---- write: decode table swept while the write is pending
        addr = {2'd1, 13'h0F0, 9'h1FF};
        wr_data = 16'h1234;
        wr_req = 1'b1;
        #1;
        tick();
        wr_req = 1'b0;
        #1;
        check("wr_acc_wr_en", wr_enable, 1);
        check("wr_acc_rd_en", rd_enable, 0);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].st);
            check($sformatf("dec_addr_st%0d", vecs[i].st), sdram_addr, vecs[i].exp_addr);
            check($sformatf("dec_ba_st%0d", vecs[i].st), sdram_ba, vecs[i].exp_ba);
            check($sformatf("dec_oe_st%0d", vecs[i].st), sdram_dq_oe, vecs[i].exp_oe);
            check($sformatf("dec_dq_st%0d", vecs[i].st), sdram_dq_out, vecs[i].exp_dq);
            check($sformatf("wr_busy_st%0d", vecs[i].st), busy, 1);
            tick();
        end
        drive(5'd0);
        check("wr_done_busy", busy, 0);
        check("wr_done_wr_en", wr_enable, 0);
        check("wr_no_rd_valid", rd_valid, 0);
        check("wr_done_oe", sdram_dq_oe, 0);
        check("wr_done_dq", sdram_dq_out, 0);

        // ---- refresh counter saturation (bench FSM holds off refresh)
        for (int i = 0; i < 1100 && refresh_cnt != 10'd1023; i++) tick();
        check("sat_reach", refresh_cnt, 1023);
        for (int i = 0; i < 4; i++) tick();
        check("sat_hold", refresh_cnt, 1023);
        drive(5'd1); tick();
        drive(5'd3); tick();
        drive(5'd0);
        check("ref_clear", refresh_cnt, 0);

        // ---- refresh at 519 preempts a just-accepted read; read issued afterwards
        for (int i = 0; i < 600 && refresh_cnt != 10'd518; i++) tick();
        check("cnt_518", refresh_cnt, 518);
        addr = {2'd3, 13'h1ABC, 9'h000};
        rd_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        #1;
        check("cnt_519", refresh_cnt, 519);
        check("ref_rd_en", rd_enable, 1);
        drive(5'd1);
        check("ref_pre_addr", sdram_addr, 13'h400);
        check("ref_pre_ba", sdram_ba, 0);
        check("ref_busy", busy, 1);
        tick();
        drive(5'd3); tick();
        drive(5'd0);
        check("ref_cnt_cleared", refresh_cnt, 0);
        check("ref_rd_en_held", rd_enable, 1);
        tick();
        drive(5'd16);
        check("ref_rd_act_ba", sdram_ba, 3);
        check("ref_rd_act_addr", sdram_addr, 13'h1ABC);
        tick();
        drive(5'd18);
        check("ref_rd_cmd_addr", sdram_addr, 13'h400);
        tick();
        sdram_dq_in = 16'hCAFE;
        drive(5'd20);
        tick();
        sdram_dq_in = 16'h0000;
        drive(5'd0);
        check("ref_rd_valid", rd_valid, 1);
        check("ref_rd_data", rd_data, 16'hCAFE);

        // ---- reset in the middle of a read
        tick();
        addr = {2'd2, 13'h0042, 9'h0AA};
        rd_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        tick();
        drive(5'd16); tick();
        drive(5'd18); tick();
        sdram_dq_in = 16'h7777;
        drive(5'd19);
        RESET = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_rd_en", rd_enable, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_refresh", refresh_cnt, 0);
        tick();
        drive(5'd8); tick();
        RESET = 1'b0;
        drive(5'd20); tick();
        check("mid_rst_no_valid", rd_valid, 0);
        check("mid_rst_no_capture", rd_data, 0);
        drive(5'd9);
        check("mid_rst_busy_init", busy, 1);
        tick();
        drive(5'd0);
        check("mid_rst_busy_idle", busy, 0);
        check("mid_rst_rd_en_idle", rd_enable, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
